axi_lite_arbiter: RTL and testbench

Two-port AXI4-Lite master arbiter. It shares one AXI4-Lite master port between the instruction-fetch SRAM-style port (read-only) and the data SRAM-style port (read/write). Each accepted request becomes exactly one AXI4-Lite transaction. Only one transaction is outstanding at a time. The block sits between the core's fetch/LSU units and the bus, and replaces the per-port combinational bridges.

---
 rtl/axi_lite_arb_pkg.sv | 23 ++
 rtl/axi_lite_arbiter_rr_arb2.sv | 36 +++
 rtl/axi_lite_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the two-port AXI4-Lite master arbiter.
package axi_lite_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WRESP = 3'd4
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // Request/grant vectors are packed as {data, inst}.
    localparam int REQ_INST = 0;
    localparam int REQ_DATA = 1;

endpackage

// File: rtl/axi_lite_arbiter_rr_arb2.sv
// Two-request round-robin grant; the pointer flips to the loser on every
// accepted grant so a sustained tie alternates between the ports.
module rr_arb2
    import axi_lite_arb_pkg::*;
(
    input  logic       aclk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic prio_data_q;

    always_comb begin
        grant = 2'b00;
        if (req[REQ_DATA] && req[REQ_INST]) begin
            if (prio_data_q) begin
                grant[REQ_DATA] = 1'b1;
            end else begin
                grant[REQ_INST] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge aclk or negedge reset) begin
        if (!reset) begin
            prio_data_q <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            prio_data_q <= grant[REQ_INST];
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI4-Lite master port between the fetch (read-only) and data
// SRAM-style ports, one outstanding transaction at a time.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for inst_ce/data_ce; grant, ack and capture request
// ST_RADDR | ar_valid asserted with captured address
// ST_RDATA | rd_ready asserted; route rd_data to owner on rd_valid
// ST_WADDR | aw_valid/wd_valid each held until its own handshake
// ST_WRESP | wr_ready asserted; signal data_write_finish on wr_valid
module axi_lite_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      reset,

    input  logic                      inst_ce,
    input  logic [ADDR_WIDTH-1:0]     inst_addr,
    output logic                      inst_ack,
    output logic [DATA_WIDTH-1:0]     inst_rdata,
    output logic                      inst_rdata_valid,

    input  logic                      data_ce,
    input  logic                      data_we,
    input  logic [ADDR_WIDTH-1:0]     data_addr,
    input  logic [DATA_WIDTH-1:0]     data_wdata,
    input  logic [DATA_WIDTH/8-1:0]   data_wmask,
    output logic                      data_ack,
    output logic [DATA_WIDTH-1:0]     data_rdata,
    output logic                      data_rdata_valid,
    output logic                      data_write_finish,
    output logic                      data_write_err,

    output logic                      ar_valid,
    input  logic                      ar_ready,
    output logic [ADDR_WIDTH-1:0]     ar_addr,
    output logic [2:0]                ar_prot,

    output logic                      aw_valid,
    input  logic                      aw_ready,
    output logic [ADDR_WIDTH-1:0]     aw_addr,
    output logic [2:0]                aw_prot,

    input  logic                      rd_valid,
    output logic                      rd_ready,
    input  logic [DATA_WIDTH-1:0]     rd_data,

    output logic                      wd_valid,
    input  logic                      wd_ready,
    output logic [DATA_WIDTH-1:0]     wd_data,
    output logic [DATA_WIDTH/8-1:0]   wstrb,

    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      wr_breap
);

    state_t                    state_q, state_d;
    owner_t                    owner_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   wmask_q;
    logic                      aw_done_q, aw_done_d;
    logic                      wd_done_q, wd_done_d;

    logic                      in_idle;
    logic [1:0]                req;
    logic [1:0]                grant;
    logic                      grant_any;
    logic                      rd_fire;

    assign in_idle   = (state_q == ST_IDLE);
    assign req       = in_idle ? {data_ce, inst_ce} : 2'b00;
    assign grant_any = (grant != 2'b00);

    rr_arb2 u_rr_arb2 (
        .aclk   (aclk),
        .reset  (reset),
        .req    (req),
        .update (in_idle),
        .grant  (grant)
    );

    // Acks are combinational from ce, so gate them while reset is held.
    assign inst_ack = grant[REQ_INST] & reset;
    assign data_ack = grant[REQ_DATA] & reset;

    always_ff @(posedge aclk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_DATA;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (in_idle && grant_any) begin
            if (grant[REQ_DATA]) begin
                owner_q <= OWN_DATA;
                addr_q  <= data_addr;
                wdata_q <= data_wdata;
                wmask_q <= data_wmask;
            end else begin
                owner_q <= OWN_INST;
                addr_q  <= inst_addr;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    always_ff @(posedge aclk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            wd_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            wd_done_q <= wd_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        wd_done_d = wd_done_q;
        case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                wd_done_d = 1'b0;
                if (grant[REQ_DATA]) begin
                    state_d = data_we ? ST_WADDR : ST_RADDR;
                end else if (grant[REQ_INST]) begin
                    state_d = ST_RADDR;
                end
            end
            ST_RADDR: begin
                if (ar_ready) begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (rd_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WADDR: begin
                if (aw_ready) begin
                    aw_done_d = 1'b1;
                end
                if (wd_ready) begin
                    wd_done_d = 1'b1;
                end
                if (aw_done_d && wd_done_d) begin
                    state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (wr_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ar_valid = (state_q == ST_RADDR);
    assign ar_addr  = addr_q;
    assign ar_prot  = AXI_PROT_DEFAULT;

    assign aw_valid = (state_q == ST_WADDR) & ~aw_done_q;
    assign aw_addr  = addr_q;
    assign aw_prot  = AXI_PROT_DEFAULT;

    assign wd_valid = (state_q == ST_WADDR) & ~wd_done_q;
    assign wd_data  = wdata_q;
    assign wstrb    = wmask_q;

    assign rd_ready = (state_q == ST_RDATA);
    assign wr_ready = (state_q == ST_WRESP);

    assign rd_fire          = rd_ready & rd_valid;
    assign inst_rdata_valid = rd_fire & (owner_q == OWN_INST);
    assign data_rdata_valid = rd_fire & (owner_q == OWN_DATA);
    assign inst_rdata       = inst_rdata_valid ? rd_data : '0;
    assign data_rdata       = data_rdata_valid ? rd_data : '0;

    assign data_write_finish = wr_ready & wr_valid;
    assign data_write_err    = data_write_finish & ~wr_breap;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: the bench plays both requesters and
// the AXI slave; expected responses are queued and matched as they appear.
module tb_axi_lite_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic              aclk = 1'b0;
    logic              reset;
    logic              inst_ce;
    logic [AW-1:0]     inst_addr;
    logic              inst_ack;
    logic [DW-1:0]     inst_rdata;
    logic              inst_rdata_valid;
    logic              data_ce;
    logic              data_we;
    logic [AW-1:0]     data_addr;
    logic [DW-1:0]     data_wdata;
    logic [DW/8-1:0]   data_wmask;
    logic              data_ack;
    logic [DW-1:0]     data_rdata;
    logic              data_rdata_valid;
    logic              data_write_finish;
    logic              data_write_err;
    logic              ar_valid;
    logic              ar_ready;
    logic [AW-1:0]     ar_addr;
    logic [2:0]        ar_prot;
    logic              aw_valid;
    logic              aw_ready;
    logic [AW-1:0]     aw_addr;
    logic [2:0]        aw_prot;
    logic              rd_valid;
    logic              rd_ready;
    logic [DW-1:0]     rd_data;
    logic              wd_valid;
    logic              wd_ready;
    logic [DW-1:0]     wd_data;
    logic [DW/8-1:0]   wstrb;
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_breap;

    axi_lite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk              (aclk),
        .reset             (reset),
        .inst_ce           (inst_ce),
        .inst_addr         (inst_addr),
        .inst_ack          (inst_ack),
        .inst_rdata        (inst_rdata),
        .inst_rdata_valid  (inst_rdata_valid),
        .data_ce           (data_ce),
        .data_we           (data_we),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_wmask        (data_wmask),
        .data_ack          (data_ack),
        .data_rdata        (data_rdata),
        .data_rdata_valid  (data_rdata_valid),
        .data_write_finish (data_write_finish),
        .data_write_err    (data_write_err),
        .ar_valid          (ar_valid),
        .ar_ready          (ar_ready),
        .ar_addr           (ar_addr),
        .ar_prot           (ar_prot),
        .aw_valid          (aw_valid),
        .aw_ready          (aw_ready),
        .aw_addr           (aw_addr),
        .aw_prot           (aw_prot),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .rd_data           (rd_data),
        .wd_valid          (wd_valid),
        .wd_ready          (wd_ready),
        .wd_data           (wd_data),
        .wstrb             (wstrb),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_breap          (wr_breap)
    );

    always #5 aclk = ~aclk;

    // kind: 0 = inst read, 1 = data read, 2 = data write
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   aw_hs_cnt = 0;
    int   aw_base;
    int   n_ack;
    logic exp_data_ack [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_resp(input logic [1:0] kind, input logic [31:0] data, input logic err);
        exp_t e;
        chk("resp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_kind", 64'(kind), 64'(e.kind));
            if (kind == 2'd2) begin
                chk("resp_write_err", 64'(err), 64'(e.err));
            end else begin
                chk("resp_rdata", 64'(data), 64'(e.data));
            end
        end
    endtask

    always @(negedge aclk) begin
        if (inst_rdata_valid)  check_resp(2'd0, inst_rdata, 1'b0);
        if (data_rdata_valid)  check_resp(2'd1, data_rdata, 1'b0);
        if (data_write_finish) check_resp(2'd2, 32'd0, data_write_err);
        if (aw_valid && aw_ready) aw_hs_cnt++;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic samp();
        @(negedge aclk);
    endtask

    task automatic push(input logic [1:0] kind, input logic [31:0] data, input logic err);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        inst_ce = 1'b1; inst_addr = '0;
        data_ce = 1'b1; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_wmask = '0;
        ar_ready = 1'b0; aw_ready = 1'b0; wd_ready = 1'b0;
        rd_valid = 1'b0; rd_data = '0; wr_valid = 1'b0; wr_breap = 1'b1;

        // reset state, with both ce high to show acks stay quiet
        samp();
        chk("rst_inst_ack", 64'(inst_ack), 64'd0);
        chk("rst_data_ack", 64'(data_ack), 64'd0);
        chk("rst_ar_valid", 64'(ar_valid), 64'd0);
        chk("rst_aw_valid", 64'(aw_valid), 64'd0);
        chk("rst_wd_valid", 64'(wd_valid), 64'd0);
        chk("rst_rd_ready", 64'(rd_ready), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_ar_addr",  64'(ar_addr),  64'd0);
        chk("rst_wd_data",  64'(wd_data),  64'd0);
        chk("rst_wstrb",    64'(wstrb),    64'd0);
        chk("rst_finish",   64'(data_write_finish), 64'd0);
        inst_ce = 1'b0; data_ce = 1'b0;
        #1 reset = 1'b1;

        // single inst read, minimum latency
        tick();
        inst_ce = 1'b1; inst_addr = 32'h0000_1000; ar_ready = 1'b1;
        push(2'd0, 32'hDEAD_BEEF, 1'b0);
        samp();
        chk("t1_inst_ack", 64'(inst_ack), 64'd1);
        chk("t1_data_ack", 64'(data_ack), 64'd0);
        chk("t1_ar_valid_c0", 64'(ar_valid), 64'd0);
        tick();
        inst_ce = 1'b0;
        samp();
        chk("t1_ar_valid_c1", 64'(ar_valid), 64'd1);
        chk("t1_ar_addr", 64'(ar_addr), 64'h1000);
        chk("t1_ar_prot", 64'(ar_prot), 64'd0);
        tick();
        ar_ready = 1'b0; rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
        samp();
        chk("t1_inst_rvalid_c2", 64'(inst_rdata_valid), 64'd1);
        chk("t1_data_rvalid_c2", 64'(data_rdata_valid), 64'd0);
        tick();
        rd_valid = 1'b0;
        samp();
        chk("t1_rd_ready_idle", 64'(rd_ready), 64'd0);

        // data write, wd_ready in cycle 1, aw_ready in cycle 3
        tick();
        data_ce = 1'b1; data_we = 1'b1; data_addr = 32'h0000_2004;
        data_wdata = 32'h1234_5678; data_wmask = 4'b0011;
        push(2'd2, 32'd0, 1'b0);
        samp();
        chk("t2_data_ack", 64'(data_ack), 64'd1);
        chk("t2_inst_ack", 64'(inst_ack), 64'd0);
        tick();
        data_ce = 1'b0; wd_ready = 1'b1;
        samp();
        chk("t2_aw_valid_c1", 64'(aw_valid), 64'd1);
        chk("t2_wd_valid_c1", 64'(wd_valid), 64'd1);
        chk("t2_aw_addr", 64'(aw_addr), 64'h2004);
        chk("t2_wd_data", 64'(wd_data), 64'h1234_5678);
        chk("t2_wstrb", 64'(wstrb), 64'h3);
        chk("t2_aw_prot", 64'(aw_prot), 64'd0);
        tick();
        wd_ready = 1'b0;
        samp();
        chk("t2_wd_valid_c2", 64'(wd_valid), 64'd0);
        chk("t2_aw_valid_c2", 64'(aw_valid), 64'd1);
        tick();
        aw_ready = 1'b1;
        samp();
        chk("t2_aw_valid_c3", 64'(aw_valid), 64'd1);
        chk("t2_aw_addr_c3", 64'(aw_addr), 64'h2004);
        tick();
        aw_ready = 1'b0; wr_valid = 1'b1; wr_breap = 1'b1;
        samp();
        chk("t2_aw_valid_c4", 64'(aw_valid), 64'd0);
        chk("t2_wr_ready", 64'(wr_ready), 64'd1);
        chk("t2_finish", 64'(data_write_finish), 64'd1);
        chk("t2_err", 64'(data_write_err), 64'd0);
        tick();
        wr_valid = 1'b0;
        samp();
        chk("t2_wr_ready_idle", 64'(wr_ready), 64'd0);

        // both write handshakes in cycle 1, error response
        aw_base = aw_hs_cnt;
        tick();
        data_ce = 1'b1; data_we = 1'b1; data_addr = 32'h0000_3000;
        data_wdata = 32'hCAFE_0001; data_wmask = 4'hF;
        aw_ready = 1'b1; wd_ready = 1'b1;
        push(2'd2, 32'd0, 1'b1);
        samp();
        chk("t4_data_ack", 64'(data_ack), 64'd1);
        tick();
        data_ce = 1'b0;
        samp();
        chk("t4_aw_valid_c1", 64'(aw_valid), 64'd1);
        chk("t4_wd_valid_c1", 64'(wd_valid), 64'd1);
        chk("t4_wstrb", 64'(wstrb), 64'hF);
        tick();
        wr_valid = 1'b1; wr_breap = 1'b0;
        samp();
        chk("t4_wr_ready_c2", 64'(wr_ready), 64'd1);
        chk("t4_aw_valid_c2", 64'(aw_valid), 64'd0);
        chk("t4_wd_valid_c2", 64'(wd_valid), 64'd0);
        chk("t4_finish", 64'(data_write_finish), 64'd1);
        chk("t4_err", 64'(data_write_err), 64'd1);
        tick();
        wr_valid = 1'b0; wr_breap = 1'b1; aw_ready = 1'b0; wd_ready = 1'b0;
        samp();
        chk("t4_wr_ready_idle", 64'(wr_ready), 64'd0);
        chk("t4_aw_valid_idle", 64'(aw_valid), 64'd0);
        chk("t4_aw_handshakes", 64'(aw_hs_cnt - aw_base), 64'd1);

        // reset in RDATA abandons the read
        tick();
        inst_ce = 1'b1; inst_addr = 32'h0000_4000; ar_ready = 1'b1;
        samp();
        chk("t5_inst_ack", 64'(inst_ack), 64'd1);
        tick();
        inst_ce = 1'b0;
        samp();
        chk("t5_ar_valid", 64'(ar_valid), 64'd1);
        tick();
        ar_ready = 1'b0;
        samp();
        chk("t5_rd_ready_rdata", 64'(rd_ready), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("t5_rst_rd_ready", 64'(rd_ready), 64'd0);
        chk("t5_rst_ar_valid", 64'(ar_valid), 64'd0);
        chk("t5_rst_ar_addr", 64'(ar_addr), 64'd0);
        samp();
        #1 reset = 1'b1;
        tick();
        rd_valid = 1'b1; rd_data = 32'hBAD0_BAD0;
        samp();
        chk("t5_stray_inst_rvalid", 64'(inst_rdata_valid), 64'd0);
        chk("t5_stray_data_rvalid", 64'(data_rdata_valid), 64'd0);
        chk("t5_stray_rd_ready", 64'(rd_ready), 64'd0);
        tick();
        rd_valid = 1'b0;
        inst_ce = 1'b1; inst_addr = 32'h0000_5000;
        push(2'd0, 32'hCAFE_F00D, 1'b0);
        samp();
        chk("t5_new_inst_ack", 64'(inst_ack), 64'd1);
        tick();
        inst_ce = 1'b0;
        samp();
        chk("t5_new_ar_addr", 64'(ar_addr), 64'h5000);
        tick();
        ar_ready = 1'b1;
        samp();
        chk("t5_ar_held", 64'(ar_valid), 64'd1);
        tick();
        ar_ready = 1'b0; rd_valid = 1'b1; rd_data = 32'hCAFE_F00D;
        samp();
        chk("t5_new_inst_rvalid", 64'(inst_rdata_valid), 64'd1);
        tick();
        rd_valid = 1'b0;

        // round robin with both ce held high, always-ready slave
        exp_data_ack[0] = 1'b1; exp_data_ack[1] = 1'b0;
        exp_data_ack[2] = 1'b1; exp_data_ack[3] = 1'b0;
        push(2'd2, 32'd0, 1'b0);
        push(2'd0, 32'hA5A5_0001, 1'b0);
        push(2'd2, 32'd0, 1'b0);
        push(2'd0, 32'hA5A5_0001, 1'b0);
        tick();
        ar_ready = 1'b1; aw_ready = 1'b1; wd_ready = 1'b1;
        rd_valid = 1'b1; rd_data = 32'hA5A5_0001; wr_valid = 1'b1; wr_breap = 1'b1;
        inst_ce = 1'b1; inst_addr = 32'h0000_7000;
        data_ce = 1'b1; data_we = 1'b1; data_addr = 32'h0000_8000;
        data_wdata = 32'h1111_2222; data_wmask = 4'hF;
        n_ack = 0;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            samp();
            if (inst_ack || data_ack) begin
                chk("rr_single_ack", 64'(inst_ack ^ data_ack), 64'd1);
                chk("rr_order", 64'(data_ack), 64'(exp_data_ack[n_ack]));
                n_ack++;
            end
        end
        chk("rr_ack_count", 64'(n_ack), 64'd4);
        tick();
        inst_ce = 1'b0; data_ce = 1'b0;
        for (int c = 0; c < 40 && sb.size() != 0; c++) begin
            samp();
        end
        chk("rr_drain", 64'(sb.size()), 64'd0);
        tick();
        ar_ready = 1'b0; aw_ready = 1'b0; wd_ready = 1'b0;
        rd_valid = 1'b0; wr_valid = 1'b0;

        // data read routed to the data port
        tick();
        data_ce = 1'b1; data_we = 1'b0; data_addr = 32'h0000_6000; ar_ready = 1'b1;
        push(2'd1, 32'h0BAD_F00D, 1'b0);
        samp();
        chk("t7_data_ack", 64'(data_ack), 64'd1);
        tick();
        data_ce = 1'b0;
        samp();
        chk("t7_ar_addr", 64'(ar_addr), 64'h6000);
        chk("t7_aw_valid", 64'(aw_valid), 64'd0);
        tick();
        ar_ready = 1'b0; rd_valid = 1'b1; rd_data = 32'h0BAD_F00D;
        samp();
        chk("t7_data_rvalid", 64'(data_rdata_valid), 64'd1);
        chk("t7_inst_rvalid", 64'(inst_rdata_valid), 64'd0);
        tick();
        rd_valid = 1'b0;
        samp();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
